// File: rtl/td4_run_ctrl_if.sv
// td4_run_ctrl_if: host command, program-load, breakpoint and CPU/memory control bundle
interface td4_run_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic          cmd_ready;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic [AW-1:0] pc;
  logic          bp_en;
  logic [AW-1:0] bp_addr;
  logic          cpu_ce;
  logic          cpu_rst;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    st;
  logic          bp_hit;
  modport master (
    output cmd_valid, cmd_op, ld_valid, ld_data, pc, bp_en, bp_addr,
    input  cmd_ready, ld_ready, cpu_ce, cpu_rst, mem_we, mem_waddr, mem_wdata, st, bp_hit
  );
  modport slave (
    input  cmd_valid, cmd_op, ld_valid, ld_data, pc, bp_en, bp_addr,
    output cmd_ready, ld_ready, cpu_ce, cpu_rst, mem_we, mem_waddr, mem_wdata, st, bp_hit
  );
endinterface

// File: rtl/td4_run_ctrl.sv
// td4_run_ctrl: run/step/halt sequencer, program loader and PC breakpoint for the TD4 core
module td4_run_ctrl #(
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int RUN_DIV = 1
) (
  input logic           clk,
  input logic           reset,
  td4_run_ctrl_if.slave bus
);
  localparam int CW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
  localparam logic [2:0] S_HALT = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2, S_LOAD = 3'd3, S_CRST = 3'd4;
  localparam logic [1:0] OP_RUN = 2'd0, OP_HALT = 2'd2, OP_LOAD = 2'd3;
  logic [2:0]    st_q, st_d;
  logic [CW-1:0] div_q, div_d;
  logic [AW-1:0] idx_q, idx_d, waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ce_q, ce_d, rst_q, rst_d, we_q, we_d, hit_q, hit_d, first_q, first_d;
  logic          rdy, cmd_acc, ld_acc, bp_stop, div_wrap;
  assign rdy      = st_q == S_HALT || st_q == S_RUN || st_q == S_STEP;
  assign cmd_acc  = bus.cmd_valid & rdy;
  assign ld_acc   = bus.ld_valid & (st_q == S_LOAD);
  assign div_wrap = div_q == CW'(RUN_DIV - 1);
  // the breakpoint must see the PC of the very cycle a pulse is due, so it gates the registered pulse
  assign bp_stop  = (st_q == S_RUN) & ce_q & ~first_q & bus.bp_en & (bus.pc == bus.bp_addr);
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= S_HALT;
      div_q   <= '0;
      idx_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      ce_q    <= 1'b0;
      rst_q   <= 1'b1;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ce_q    <= ce_d;
      rst_q   <= rst_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
      first_q <= first_d;
    end
  end
  always_comb begin
    st_d = S_RUN;
    if (bp_stop) st_d = S_HALT;
    else if (cmd_acc && bus.cmd_op == OP_LOAD) st_d = S_LOAD;
    else if (cmd_acc && bus.cmd_op == OP_HALT) st_d = S_HALT;
    else if (cmd_acc && st_q == S_HALT) st_d = bus.cmd_op == OP_RUN ? S_RUN : S_STEP;
    else if (st_q == S_LOAD) st_d = ld_acc && &idx_q ? S_CRST : S_LOAD;
    else if (st_q != S_RUN) st_d = S_HALT;
  end
  always_comb begin
    div_d   = (st_d == S_RUN && st_q == S_RUN && !div_wrap) ? div_q + CW'(1) : '0;
    ce_d    = st_d == S_STEP || (st_d == S_RUN && div_d == CW'(RUN_DIV - 1));
    rst_d   = st_d == S_LOAD || st_d == S_CRST;
    first_d = st_d == S_RUN && (st_q != S_RUN || (first_q && !ce_q));
    hit_d   = bp_stop | (hit_q & ~(st_d == S_RUN && st_q != S_RUN));
    we_d    = ld_acc;
    waddr_d = ld_acc ? idx_q : (st_d == S_LOAD && st_q != S_LOAD) ? '0 : waddr_q;
    wdata_d = ld_acc ? bus.ld_data : wdata_q;
    idx_d   = st_q != S_LOAD ? '0 : idx_q + AW'(ld_acc);
  end
  assign bus.cmd_ready = rdy;
  assign bus.ld_ready  = st_q == S_LOAD;
  assign bus.cpu_ce    = ce_q & ~bp_stop;
  assign bus.cpu_rst   = rst_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.st        = st_q;
  assign bus.bp_hit    = hit_q;
endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb_td4_run_ctrl: directed checks of load, step, divided run, breakpoint, halt and load abort
module tb_td4_run_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  td4_run_ctrl_if #(.AW(4), .DW(8)) bus ();
  td4_run_ctrl #(.AW(4), .DW(8), .RUN_DIV(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) bus.pc <= bus.cpu_rst ? 4'd0 : bus.pc + (bus.cpu_ce ? 4'd1 : 4'd0);
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_cmd(input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  task automatic test_reset;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.ld_valid = 1'b0; bus.ld_data = 8'd0;
    bus.bp_en = 1'b0; bus.bp_addr = 4'd0;
    reset = 1'b1;
    tick();
    checks++; if (bus.st !== 3'd0) begin errors++; $display("FAIL rst_st got %0d exp 0", bus.st); end
    checks++; if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst got %b exp 1", bus.cpu_rst); end
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL rst_cpu_ce got %b exp 0", bus.cpu_ce); end
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_waddr !== 4'd0 || bus.mem_wdata !== 8'd0) begin errors++; $display("FAIL rst_mem got we=%b a=%0d d=%0h exp 0/0/0", bus.mem_we, bus.mem_waddr, bus.mem_wdata); end
    checks++; if (bus.bp_hit !== 1'b0) begin errors++; $display("FAIL rst_bp_hit got %b exp 0", bus.bp_hit); end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got cmd=%b ld=%b exp 1/0", bus.cmd_ready, bus.ld_ready); end
    reset = 1'b0;
    tick();
    checks++; if (bus.cpu_rst !== 1'b0 || bus.st !== 3'd0) begin errors++; $display("FAIL rst_release got rst=%b st=%0d exp 0/0", bus.cpu_rst, bus.st); end
  endtask
  task automatic test_load;
    send_cmd(2'd3);
    checks++; if (bus.st !== 3'd3 || bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL load_entry got st=%0d rst=%b exp 3/1", bus.st, bus.cpu_rst); end
    checks++; if (bus.ld_ready !== 1'b1 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL load_ready got ld=%b cmd=%b exp 1/0", bus.ld_ready, bus.cmd_ready); end
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.ld_data = 8'(i);
      tick();
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 4'(i) || bus.mem_wdata !== 8'(i)) begin errors++; $display("FAIL load_byte%0d got we=%b a=%0d d=%0h exp 1/%0d/%0h", i, bus.mem_we, bus.mem_waddr, bus.mem_wdata, i, i); end
      checks++; if (bus.cpu_rst !== 1'b1 || bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL load_cpu%0d got rst=%b ce=%b exp 1/0", i, bus.cpu_rst, bus.cpu_ce); end
      checks++; if (bus.st !== (i == 15 ? 3'd4 : 3'd3)) begin errors++; $display("FAIL load_st%0d got %0d exp %0d", i, bus.st, i == 15 ? 4 : 3); end
    end
    bus.ld_valid = 1'b0;
    tick();
    checks++; if (bus.st !== 3'd0 || bus.cpu_rst !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL load_done got st=%0d rst=%b we=%b exp 0/0/0", bus.st, bus.cpu_rst, bus.mem_we); end
    checks++; if (bus.pc !== 4'd0) begin errors++; $display("FAIL load_pc got %0d exp 0", bus.pc); end
  endtask
  task automatic test_step;
    bus.ld_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_cmd(2'd1);
      checks++; if (bus.st !== 3'd2 || bus.cpu_ce !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL step%0d_pulse got st=%0d ce=%b we=%b exp 2/1/0", k, bus.st, bus.cpu_ce, bus.mem_we); end
      tick();
      checks++; if (bus.st !== 3'd0 || bus.cpu_ce !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL step%0d_after got st=%0d ce=%b we=%b exp 0/0/0", k, bus.st, bus.cpu_ce, bus.mem_we); end
    end
    bus.ld_valid = 1'b0;
    checks++; if (bus.pc !== 4'd3 || bus.ld_ready !== 1'b0) begin errors++; $display("FAIL step_pc got pc=%0d ld_ready=%b exp 3/0", bus.pc, bus.ld_ready); end
  endtask
  task automatic test_run_div_halt;
    send_cmd(2'd0);
    for (int i = 1; i <= 12; i++) begin
      checks++; if (bus.st !== 3'd1 || bus.cpu_ce !== (i % 3 == 0)) begin errors++; $display("FAIL run_cycle%0d got st=%0d ce=%b exp 1/%b", i, bus.st, bus.cpu_ce, i % 3 == 0); end
      if (i == 6) begin bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; end
      else if (i == 12) begin bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; end
      else bus.cmd_valid = 1'b0;
      tick();
    end
    bus.cmd_valid = 1'b0;
    checks++; if (bus.st !== 3'd0 || bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL halt_cmd got st=%0d ce=%b exp 0/0", bus.st, bus.cpu_ce); end
    tick();
    checks++; if (bus.cpu_ce !== 1'b0 || bus.pc !== 4'd7) begin errors++; $display("FAIL halt_hold got ce=%b pc=%0d exp 0/7", bus.cpu_ce, bus.pc); end
  endtask
  task automatic test_breakpoint;
    logic seen;
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.bp_en = 1'b1;
    bus.bp_addr = 4'd5;
    send_cmd(2'd0);
    seen = 1'b0;
    n = 0;
    while (bus.st == 3'd1 && n < 60) begin
      if (bus.cpu_ce && bus.pc == 4'd5) seen = 1'b1;
      tick();
      n++;
    end
    checks++; if (bus.st !== 3'd0) begin errors++; $display("FAIL bp_stop got st=%0d exp 0 after %0d cycles", bus.st, n); end
    checks++; if (bus.pc !== 4'd5 || bus.bp_hit !== 1'b1) begin errors++; $display("FAIL bp_state got pc=%0d hit=%b exp 5/1", bus.pc, bus.bp_hit); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bp_no_ce got ce_at_bp=%b exp 0", seen); end
    send_cmd(2'd0);
    checks++; if (bus.st !== 3'd1 || bus.bp_hit !== 1'b0) begin errors++; $display("FAIL bp_rerun got st=%0d hit=%b exp 1/0", bus.st, bus.bp_hit); end
    tick();
    tick();
    checks++; if (bus.cpu_ce !== 1'b1 || bus.pc !== 4'd5) begin errors++; $display("FAIL bp_resume got ce=%b pc=%0d exp 1/5", bus.cpu_ce, bus.pc); end
    tick();
    checks++; if (bus.pc !== 4'd6 || bus.st !== 3'd1) begin errors++; $display("FAIL bp_progress got pc=%0d st=%0d exp 6/1", bus.pc, bus.st); end
    send_cmd(2'd2);
    bus.bp_en = 1'b0;
  endtask
  task automatic test_load_abort;
    send_cmd(2'd3);
    for (int i = 0; i < 7; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data = 8'hA0 + 8'(i);
      tick();
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 4'(i) || bus.mem_wdata !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL abort_byte%0d got we=%b a=%0d d=%0h exp 1/%0d/%0h", i, bus.mem_we, bus.mem_waddr, bus.mem_wdata, i, 8'hA0 + 8'(i)); end
      bus.ld_valid = 1'b0;
      tick();
      checks++; if (bus.mem_we !== 1'b0 || bus.st !== 3'd3) begin errors++; $display("FAIL abort_gap%0d got we=%b st=%0d exp 0/3", i, bus.mem_we, bus.st); end
    end
    reset = 1'b1;
    tick();
    checks++; if (bus.st !== 3'd0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL abort_reset got st=%0d we=%b exp 0/0", bus.st, bus.mem_we); end
    reset = 1'b0;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1 || bus.st !== 3'd0) begin errors++; $display("FAIL abort_ready got rdy=%b st=%0d exp 1/0", bus.cmd_ready, bus.st); end
    send_cmd(2'd3);
    bus.ld_valid = 1'b1;
    bus.ld_data = 8'h5A;
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 4'd0 || bus.mem_wdata !== 8'h5A) begin errors++; $display("FAIL reload_first got we=%b a=%0d d=%0h exp 1/0/5a", bus.mem_we, bus.mem_waddr, bus.mem_wdata); end
    bus.ld_valid = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 2'd0;
    tick();
    checks++; if (bus.st !== 3'd3 || bus.cmd_ready !== 1'b0 || bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL load_cmd_block got st=%0d rdy=%b ce=%b exp 3/0/0", bus.st, bus.cmd_ready, bus.cpu_ce); end
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_load();
    test_step();
    test_run_div_halt();
    test_breakpoint();
    test_load_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
